noc_run_ctrl: RTL and testbench

- Parametrised run controller for multi-client NoC benches and on-chip self-test.
- Sequences client reset and latches per-client completion, then waits for the network to drain to quiescence before declaring pass or fail.
- Sits beside the `verif_client` instances and the `pi_switch_top` fabric.
- Replaces ad-hoc initial-block sequencing with synthesizable logic that scales to any client count, watches link activity and enforces a watchdog.

---
 rtl/noc_run_ctrl.sv | 84 ++++++++
 tb/tb_noc_run_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/noc_run_ctrl.sv
// noc_run_ctrl: sequences client reset, latches per-client completion, waits
// for link quiescence, then reports pass or fail under a watchdog.
module noc_run_ctrl #(
   parameter int N_CLIENTS      = 4,
   parameter int N_LINKS        = 16,
   parameter int RST_CYCLES     = 2,
   parameter int DRAIN_CYCLES   = 1000,
   parameter int QUIESCE        = 1,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 32,
   localparam int EW = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CLIENTS-1:0] client_done,
   input  logic [N_CLIENTS-1:0] client_err,
   input  logic [N_CLIENTS-1:0] client_mask,
   input  logic [N_LINKS-1:0]   link_active,
   output logic                 client_rst,
   output logic [2:0]           state,
   output logic [N_CLIENTS-1:0] done_seen,
   output logic [CNT_W-1:0]     run_cycles,
   output logic                 finish,
   output logic                 pass,
   output logic                 fail,
   output logic [1:0]           fail_code,
   output logic [EW-1:0]        err_client
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [2:0] RST_HOLD = 3'd0, RUN = 3'd1, DRAIN = 3'd2, PASS = 3'd3, FAIL = 3'd4;
   logic [2:0]           nxt;
   logic [RW-1:0]        rst_cnt;
   logic [DW-1:0]        drain_cnt;
   logic [N_CLIENTS-1:0] err_v;
   logic [EW-1:0]        err_idx;
   logic                 active, idle, drain_done, tmo;
   assign err_v      = client_err & ~client_mask;
   assign active     = state == RUN || state == DRAIN;
   assign idle       = !(QUIESCE != 0 && |link_active);
   assign drain_done = state == DRAIN && idle && drain_cnt == DW'(DRAIN_CYCLES - 1);
   assign tmo        = TIMEOUT_CYCLES != 0 && run_cycles == CNT_W'(TIMEOUT_CYCLES - 1);
   always_comb begin
      err_idx = '0;
      for (int i = N_CLIENTS - 1; i >= 0; i--)
         if (err_v[i]) err_idx = EW'(i);
   end
   always_ff @(posedge clk)
      state <= rst ? RST_HOLD : nxt;
   // Later assignments win: error > pass > timeout > normal progress.
   always_comb begin
      nxt = state;
      if (state == RST_HOLD && rst_cnt == RW'(RST_CYCLES - 1)) nxt = RUN;
      if (state == RUN && &(done_seen | client_mask)) nxt = DRAIN;
      if (active && tmo) nxt = FAIL;
      if (drain_done) nxt = PASS;
      if (active && |err_v) nxt = FAIL;
   end
   always_comb begin
      client_rst = state == RST_HOLD;
      pass       = state == PASS;
      fail       = state == FAIL;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_cnt    <= '0;
         drain_cnt  <= '0;
         done_seen  <= '0;
         run_cycles <= '0;
         finish     <= 1'b0;
         fail_code  <= 2'd0;
         err_client <= '0;
      end else begin
         rst_cnt    <= state == RST_HOLD ? rst_cnt + RW'(1) : rst_cnt;
         drain_cnt  <= state != DRAIN ? '0 : idle ? drain_cnt + DW'(1) : '0;
         done_seen  <= state == RUN ? done_seen | (client_done & ~client_mask) : done_seen;
         // The cycle count freezes on the edge that leaves RUN/DRAIN.
         run_cycles <= active && (nxt == RUN || nxt == DRAIN) && !(&run_cycles) ? run_cycles + CNT_W'(1) : run_cycles;
         finish     <= active && (nxt == PASS || nxt == FAIL);
         fail_code  <= active && |err_v ? 2'd1 : active && nxt == FAIL ? 2'd2 : fail_code;
         err_client <= active && |err_v ? err_idx : err_client;
      end
   end
endmodule

// File: tb/tb_noc_run_ctrl.sv
// tb_noc_run_ctrl: scoreboard bench for noc_run_ctrl; instance a quiesces with a
// 50-cycle watchdog, instance b uses a fixed drain and no watchdog.
module tb_noc_run_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic [3:0]  client_done = '0, client_err = '0, client_mask = '0;
   logic [15:0] link_active = '0;
   logic        client_rst_a, finish_a, pass_a, fail_a, client_rst_b, finish_b, pass_b, fail_b;
   logic [2:0]  state_a, state_b;
   logic [3:0]  done_seen_a, done_seen_b;
   logic [31:0] run_cycles_a, run_cycles_b;
   logic [1:0]  fail_code_a, fail_code_b, err_client_a, err_client_b;
   typedef struct {logic [2:0] st; logic [1:0] code; logic [1:0] ec; logic [31:0] rc; int n;} exp_t;
   exp_t        q[$];
   logic [2:0]  st_hist [0:63];
   int          vec = 0, miss = 0, fb = 0;

   noc_run_ctrl #(.N_CLIENTS(4), .N_LINKS(16), .RST_CYCLES(2), .DRAIN_CYCLES(10), .QUIESCE(1),
                  .TIMEOUT_CYCLES(50), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .client_done(client_done), .client_err(client_err),
      .client_mask(client_mask), .link_active(link_active), .client_rst(client_rst_a),
      .state(state_a), .done_seen(done_seen_a), .run_cycles(run_cycles_a), .finish(finish_a),
      .pass(pass_a), .fail(fail_a), .fail_code(fail_code_a), .err_client(err_client_a));

   noc_run_ctrl #(.N_CLIENTS(4), .N_LINKS(16), .RST_CYCLES(2), .DRAIN_CYCLES(10), .QUIESCE(0),
                  .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .client_done(client_done), .client_err(client_err),
      .client_mask(client_mask), .link_active(link_active), .client_rst(client_rst_b),
      .state(state_b), .done_seen(done_seen_b), .run_cycles(run_cycles_b), .finish(finish_b),
      .pass(pass_b), .fail(fail_b), .fail_code(fail_code_b), .err_client(err_client_b));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset(input logic [3:0] mask);
      rst = 1'b1; client_mask = mask; client_done = '0; client_err = '0; link_active = '0;
      tick;
      vec++;
      if ({state_a, client_rst_a, done_seen_a, run_cycles_a, finish_a, pass_a, fail_a, fail_code_a, err_client_a}
          !== {3'd0, 1'b1, 4'd0, 32'd0, 3'b000, 2'd0, 2'd0}) begin
         miss++;
         $display("FAIL reset_values: state=%0d client_rst=%b done_seen=%b run_cycles=%0d fin/pass/fail=%b%b%b code=%0d ec=%0d, required all reset values",
                  state_a, client_rst_a, done_seen_a, run_cycles_a, finish_a, pass_a, fail_a, fail_code_a, err_client_a);
      end
      rst = 1'b0;
      tick;
      vec++;
      if (state_a !== 3'd0 || client_rst_a !== 1'b1) begin
         miss++; $display("FAIL rst_hold_e1: state=%0d client_rst=%b, required 0/1", state_a, client_rst_a);
      end
      tick;
      vec++;
      if (state_a !== 3'd1 || client_rst_a !== 1'b0 || state_b !== 3'd1) begin
         miss++; $display("FAIL rst_release_e2: state=%0d client_rst=%b state_b=%0d, required 1/0/1", state_a, client_rst_a, state_b);
      end
   endtask

   // Run edges are numbered from 1 starting at the first edge seen in RUN.
   task automatic drive_run(input int d0, input int d1, input int d2, input int d3,
                            input logic [3:0] ev, input int ea, input int act, input int maxn);
      exp_t e;
      int fa;
      fa = 0; fb = 0;
      for (int n = 1; n <= maxn && fa == 0; n++) begin
         client_done = {d3 != 0 && n >= d3, d2 != 0 && n >= d2, d1 != 0 && n >= d1, d0 != 0 && n >= d0};
         client_err  = (ea != 0 && n >= ea) ? ev : 4'd0;
         link_active = (n == act) ? 16'h0008 : 16'h0000;
         tick;
         st_hist[n] = state_a;
         if (finish_b && fb == 0) fb = n;
         if (finish_a) fa = n;
      end
      e = q.pop_front();
      vec++;
      if (fa == 0) begin
         miss++; $display("FAIL finish_wait: no finish within %0d edges, required finish at edge %0d", maxn, e.n);
      end else if ({state_a, fail_code_a, err_client_a, run_cycles_a, fa} !== {e.st, e.code, e.ec, e.rc, e.n}) begin
         miss++;
         $display("FAIL sb_result: state=%0d code=%0d ec=%0d run_cycles=%0d edge=%0d, required %0d/%0d/%0d/%0d/%0d",
                  state_a, fail_code_a, err_client_a, run_cycles_a, fa, e.st, e.code, e.ec, e.rc, e.n);
      end
      tick;
      if (finish_b && fb == 0) fb = fa + 1;
      vec++;
      if (finish_a !== 1'b0 || state_a !== e.st || run_cycles_a !== e.rc) begin
         miss++; $display("FAIL finish_pulse: finish=%b state=%0d run_cycles=%0d one edge later, required 0/%0d/%0d",
                          finish_a, state_a, run_cycles_a, e.st, e.rc);
      end
   endtask

   task automatic test_normal_pass;
      test_reset(4'h0);
      q.push_back('{3'd3, 2'd0, 2'd0, 32'd22, 23});
      drive_run(5, 7, 9, 12, 4'h0, 0, 0, 40);
      vec++;
      if (st_hist[12] !== 3'd1 || st_hist[13] !== 3'd2 || pass_a !== 1'b1 || fail_a !== 1'b0) begin
         miss++; $display("FAIL normal_drain_entry: st12=%0d st13=%0d pass=%b fail=%b, required 1/2/1/0", st_hist[12], st_hist[13], pass_a, fail_a);
      end
      vec++;
      if (fb !== 23 || state_b !== 3'd3 || run_cycles_b !== 32'd22) begin
         miss++; $display("FAIL normal_b: edge=%0d state=%0d rc=%0d, required 23/3/22", fb, state_b, run_cycles_b);
      end
   endtask

   task automatic test_quiesce;
      test_reset(4'h0);
      q.push_back('{3'd3, 2'd0, 2'd0, 32'd28, 29});
      drive_run(5, 7, 9, 12, 4'h0, 0, 19, 40);
      vec++;
      if (fb !== 23 || state_b !== 3'd3 || run_cycles_b !== 32'd22) begin
         miss++; $display("FAIL fixed_drain_b: edge=%0d state=%0d rc=%0d, required 23/3/22", fb, state_b, run_cycles_b);
      end
   endtask

   task automatic test_error;
      test_reset(4'h0);
      q.push_back('{3'd4, 2'd1, 2'd1, 32'd2, 3});
      drive_run(0, 0, 0, 0, 4'b0110, 3, 0, 20);
      vec++;
      if (fail_a !== 1'b1 || pass_a !== 1'b0 || fb !== 3 || err_client_b !== 2'd1 || fail_code_b !== 2'd1) begin
         miss++; $display("FAIL err_unmasked: fail=%b pass=%b b_edge=%0d b_ec=%0d b_code=%0d, required 1/0/3/1/1",
                          fail_a, pass_a, fb, err_client_b, fail_code_b);
      end
      test_reset(4'b0010);
      q.push_back('{3'd4, 2'd1, 2'd2, 32'd2, 3});
      drive_run(0, 0, 0, 0, 4'b0110, 3, 0, 20);
      test_reset(4'b0110);
      q.push_back('{3'd3, 2'd0, 2'd0, 32'd15, 16});
      drive_run(5, 5, 5, 5, 4'b0110, 1, 0, 30);
      vec++;
      if (done_seen_a !== 4'b1001 || fail_a !== 1'b0) begin
         miss++; $display("FAIL err_masked: done_seen=%b fail=%b, required 1001/0", done_seen_a, fail_a);
      end
   endtask

   task automatic test_watchdog;
      test_reset(4'h0);
      q.push_back('{3'd4, 2'd2, 2'd0, 32'd49, 50});
      drive_run(5, 5, 5, 0, 4'h0, 0, 0, 60);
      for (int i = 0; i < 9; i++) tick;
      vec++;
      if (state_b !== 3'd1 || run_cycles_b !== 32'd60 || run_cycles_a !== 32'd49 || state_a !== 3'd4) begin
         miss++; $display("FAIL watchdog_hold: b_state=%0d b_rc=%0d a_rc=%0d a_state=%0d, required 1/60/49/4",
                          state_b, run_cycles_b, run_cycles_a, state_a);
      end
      test_reset(4'h0);
      q.push_back('{3'd3, 2'd0, 2'd0, 32'd49, 50});
      drive_run(5, 5, 5, 39, 4'h0, 0, 0, 60);
      vec++;
      if (fb !== 50 || pass_b !== 1'b1) begin
         miss++; $display("FAIL pass_vs_timeout_b: edge=%0d pass=%b, required 50/1", fb, pass_b);
      end
   endtask

   task automatic test_mid_reset;
      test_reset(4'h0);
      client_done = 4'hF;
      tick; tick; tick;
      vec++;
      if (state_a !== 3'd2 || done_seen_a !== 4'hF) begin
         miss++; $display("FAIL mid_in_drain: state=%0d done_seen=%b, required 2/1111", state_a, done_seen_a);
      end
      test_reset(4'h0);
      q.push_back('{3'd3, 2'd0, 2'd0, 32'd22, 23});
      drive_run(5, 7, 9, 12, 4'h0, 0, 0, 40);
   endtask

   task automatic test_all_masked;
      test_reset(4'hF);
      q.push_back('{3'd3, 2'd0, 2'd0, 32'd10, 11});
      drive_run(0, 0, 0, 0, 4'hF, 1, 0, 30);
      vec++;
      if (st_hist[1] !== 3'd2 || done_seen_a !== 4'h0) begin
         miss++; $display("FAIL all_masked: state_after_e1=%0d done_seen=%b, required 2/0000", st_hist[1], done_seen_a);
      end
   endtask

   initial begin
      test_normal_pass;
      test_quiesce;
      test_error;
      test_watchdog;
      test_mid_reset;
      test_all_masked;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
